mult_rr_sched: RTL

//  Round-robin scheduler sharing one multi-cycle radix-4 Booth multiplier between N_REQ requesters.

---
 rtl/mult_sched_pkg.sv | 24 ++
 rtl/mult_rr_sched_arbiter.sv | 33 +++
 rtl/mult_rr_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Holds the scheduler state enum, default widths and small index helpers.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } sched_state_e;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_WIDTH_M     = 8;
    localparam int DEF_WIDTH_R     = 8;
    localparam int DEF_TIMEOUT_CYC = 64;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mult_rr_sched_arbiter.sv
// N-way round-robin picker: first asserted request at or after the pointer,
// wrapping, as a one-hot grant plus its binary index.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int N   = DEF_N_REQ,
    parameter int IDW = id_width(DEF_N_REQ)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    logic [IDW-1:0] k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = IDW'(wrap_idx(int'(ptr_i), i, N));
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one multi-cycle multiplier between N_REQ requesters.
// Optional ISSUE-phase timeout abort is enabled with `define MULT_SCHED_TIMEOUT_EN.
module mult_rr_sched
    import mult_sched_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int WIDTH_M     = DEF_WIDTH_M,
    parameter int WIDTH_R     = DEF_WIDTH_R,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_vld,
    output logic [N_REQ-1:0]             req_rdy,
    input  logic [N_REQ*WIDTH_M-1:0]     req_a,
    input  logic [N_REQ*WIDTH_R-1:0]     req_b,
    output logic                         mul_vld,
    output logic [WIDTH_M-1:0]           mul_a,
    output logic [WIDTH_R-1:0]           mul_b,
    input  logic [WIDTH_M+WIDTH_R-1:0]   mul_p,
    input  logic                         mul_done,
    output logic                         rsp_vld,
    input  logic                         rsp_rdy,
    output logic [$clog2(N_REQ)-1:0]     rsp_id,
    output logic [WIDTH_M+WIDTH_R-1:0]   rsp_data,
    output logic                         rsp_err
);

    localparam int IDW = $clog2(N_REQ);
    localparam int PW  = WIDTH_M + WIDTH_R;

    // Handshakes: a request transfers on a cycle with req_vld[i] & req_rdy[i];
    // a response transfers on rsp_vld & rsp_rdy; mul_vld is held until mul_done.
    sched_state_e       state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH_M-1:0] a_q, a_d;
    logic [WIDTH_R-1:0] b_q, b_d;
    logic [PW-1:0]      data_q, data_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   gnt;
    logic [IDW-1:0]     win;
    logic               any;
    logic               timeout;

    rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
        .req_i (req_vld),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win),
        .any_o (any)
    );

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != ST_ISSUE) cnt_q <= '0;
        else                            cnt_q <= cnt_q + 1'b1;
    end

    // Fires on the TIMEOUT_CYC-th ISSUE cycle that has no mul_done.
    assign timeout = (state_q == ST_ISSUE) && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    // Abort path absent; the limit is only referenced to keep one parameter list.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        err_d   = err_q;
        req_rdy = '0;
        mul_vld = 1'b0;
        rsp_vld = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_rdy = rst ? '0 : gnt;
                if (any) begin
                    state_d = ST_ISSUE;
                    id_d    = win;
                    a_d     = req_a[int'(win)*WIDTH_M +: WIDTH_M];
                    b_d     = req_b[int'(win)*WIDTH_R +: WIDTH_R];
                    ptr_d   = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                mul_vld = 1'b1;
                // mul_p is only valid alongside mul_done, so capture it now.
                if (mul_done) begin
                    data_d  = mul_p;
                    state_d = ST_RESP;
                end else if (timeout) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign mul_a    = a_q;
    assign mul_b    = b_q;
    assign rsp_id   = id_q;
    assign rsp_data = data_q;
    assign rsp_err  = err_q;

endmodule
